sr_pulse_gen: RTL and testbench



---
 rtl/sr_pulse_gen.sv | 145 ++++++++++++++
 tb/tb_sr_pulse_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_gen.sv
// Turns two bouncy push buttons into clean, mutually exclusive S/R pulses for latchSR,
// with a forced idle gap after every pulse and one-deep pending requests per channel.
module sr_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int GAP_CYCLES      = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

  // Channel 0 is set, channel 1 is reset.
  logic [1:0]    btn;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_prev;
  logic [DW-1:0] deb_cnt [2];

  logic   set_edge;
  logic   reset_edge;
  logic   both;
  logic   set_req;
  logic   reset_req;
  logic   take_r;
  logic   take_s;
  logic   pend_s;
  logic   pend_r;
  state_t state;
  logic [CW-1:0] cnt;

  assign btn = {reset_btn, set_btn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Simultaneous set and reset edges cancel each other and are never remembered.
  assign set_edge   = deb[0] & ~deb_prev[0];
  assign reset_edge = deb[1] & ~deb_prev[1];
  assign both       = set_edge & reset_edge;
  assign set_req    = set_edge & ~both;
  assign reset_req  = reset_edge & ~both;

  assign take_r = (state == IDLE) && (reset_req || pend_r);
  assign take_s = (state == IDLE) && !take_r && (set_req || pend_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_s   <= 1'b0;
      pend_r   <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      conflict <= both;
      pend_r   <= take_r ? 1'b0 : (pend_r | reset_req);
      pend_s   <= take_s ? 1'b0 : (pend_s | set_req);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (take_r) begin
            state <= PULSE_R;
            R     <= 1'b1;
            busy  <= 1'b1;
          end else if (take_s) begin
            state <= PULSE_S;
            S     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        PULSE_S, PULSE_R: begin
          if (cnt == PULSE_LAST) begin
            cnt <= '0;
            S   <= 1'b0;
            R   <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          S     <= 1'b0;
          R     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed bench for sr_pulse_gen: stimulus queues expected pulses (kind, start cycle),
// a negedge monitor measures every S/R pulse and checks it against that queue.
module tb_sr_pulse_gen;

  localparam int PULSE = 2;
  localparam int GAP   = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic set_btn;
  logic reset_btn;
  logic S;
  logic R;
  logic busy;
  logic conflict;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  bit sweep       = 1'b0;

  typedef struct {
    bit is_r;
    int start;
  } exp_t;

  exp_t exp_q[$];

  sr_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .set_btn(set_btn),
    .reset_btn(reset_btn),
    .S(S),
    .R(R),
    .busy(busy),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input bit is_r, input int start);
    exp_t e;
    e.is_r  = is_r;
    e.start = start;
    exp_q.push_back(e);
  endtask

  // Pulse tracker: cur is 0 idle, 1 for S, 2 for R, sampled mid-cycle.
  int prev_cur    = 0;
  int width       = 0;
  int start       = 0;
  int last_end    = 0;
  bit have_last   = 1'b0;
  bit start_sweep = 1'b0;

  always @(negedge clk) begin
    int   cur;
    exp_t e;
    cur = S ? 1 : (R ? 2 : 0);
    vectors++;
    if (S && R) begin
      miscompares++;
      $display("[TB] FAIL exclusive: S=%0b R=%0b at cycle %0d, required never both", S, R, cyc);
    end
    if (cur != prev_cur) begin
      if (prev_cur != 0) begin
        last_end  = cyc - 1;
        have_last = 1'b1;
        check_int("pulse_width", width, PULSE);
        if (!start_sweep) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_pulse: kind %0d started at cycle %0d, required none", prev_cur, start);
          end else begin
            e = exp_q.pop_front();
            check_int("pulse_kind", prev_cur, e.is_r ? 2 : 1);
            check_int("pulse_start", start, e.start);
          end
        end
      end
      if (cur != 0) begin
        if (have_last) begin
          vectors++;
          if (cyc - last_end - 1 < GAP) begin
            miscompares++;
            $display("[TB] FAIL idle_gap: got %0d idle cycles, required >= %0d", cyc - last_end - 1, GAP);
          end
        end
        start       = cyc;
        width       = 1;
        start_sweep = sweep;
      end
    end else if (cur != 0) begin
      width++;
    end
    prev_cur = cur;
  end

  initial begin
    int t0;
    rst_n     = 1'b1;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    #2 rst_n = 1'b0;
    wait_cycles(2);
    check_int("reset_S", int'(S), 0);
    check_int("reset_R", int'(R), 0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_conflict", int'(conflict), 0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Clean set press: S at +7 for 2 cycles, busy for 12 cycles.
    t0 = cyc;
    set_btn = 1'b1;
    expect_pulse(1'b0, t0 + 7);
    wait_cycles(6);
    check_int("clean_busy_before", int'(busy), 0);
    wait_cycles(1);
    check_int("clean_busy_first", int'(busy), 1);
    wait_cycles(11);
    check_int("clean_busy_last", int'(busy), 1);
    wait_cycles(1);
    check_int("clean_busy_after", int'(busy), 0);
    wait_cycles(1);
    set_btn = 1'b0;
    wait_cycles(15);
    check_int("clean_queue_drained", exp_q.size(), 0);

    // Bounce 1,0,1,0 then hold: only the final stable press counts.
    t0 = cyc;
    set_btn = 1'b1;
    wait_cycles(1);
    set_btn = 1'b0;
    wait_cycles(1);
    set_btn = 1'b1;
    wait_cycles(1);
    set_btn = 1'b0;
    wait_cycles(1);
    set_btn = 1'b1;
    expect_pulse(1'b0, t0 + 11);
    wait_cycles(6);
    check_int("bounce_no_early_S", int'(S), 0);
    wait_cycles(15);
    set_btn = 1'b0;
    wait_cycles(20);
    check_int("bounce_queue_drained", exp_q.size(), 0);

    // Reset pressed during PULSE_S, set re-pressed during GAP: R first, then S.
    t0 = cyc;
    set_btn = 1'b1;
    expect_pulse(1'b0, t0 + 7);
    expect_pulse(1'b1, t0 + 20);
    expect_pulse(1'b0, t0 + 33);
    wait_cycles(1);
    reset_btn = 1'b1;
    wait_cycles(5);
    set_btn = 1'b0;
    wait_cycles(4);
    set_btn   = 1'b1;
    reset_btn = 1'b0;
    wait_cycles(9);
    check_int("prio_idle_busy", int'(busy), 0);
    wait_cycles(1);
    check_int("prio_R_first", int'(R), 1);
    wait_cycles(10);
    set_btn = 1'b0;
    wait_cycles(30);
    check_int("prio_queue_drained", exp_q.size(), 0);

    // Simultaneous edges: one-cycle conflict, no pulse, never busy.
    t0 = cyc;
    set_btn   = 1'b1;
    reset_btn = 1'b1;
    wait_cycles(6);
    check_int("conflict_before", int'(conflict), 0);
    wait_cycles(1);
    check_int("conflict_pulse", int'(conflict), 1);
    check_int("conflict_busy", int'(busy), 0);
    wait_cycles(1);
    check_int("conflict_after", int'(conflict), 0);
    check_int("conflict_busy_after", int'(busy), 0);
    wait_cycles(2);
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    wait_cycles(15);
    check_int("conflict_queue_drained", exp_q.size(), 0);

    // Reset asserted in the second R cycle: outputs drop at once.
    t0 = cyc;
    reset_btn = 1'b1;
    expect_pulse(1'b1, t0 + 7);
    wait_cycles(8);
    check_int("midreset_R_high", int'(R), 1);
    #2;
    rst_n     = 1'b0;
    reset_btn = 1'b0;
    #1;
    check_int("midreset_R_drop", int'(R), 0);
    check_int("midreset_busy_drop", int'(busy), 0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(20);
    check_int("midreset_busy_idle", int'(busy), 0);
    check_int("midreset_queue_drained", exp_q.size(), 0);

    // Set held through reset release gives exactly one pulse.
    rst_n   = 1'b0;
    set_btn = 1'b1;
    wait_cycles(3);
    t0 = cyc;
    rst_n = 1'b1;
    expect_pulse(1'b0, t0 + 7);
    wait_cycles(25);
    set_btn = 1'b0;
    wait_cycles(15);
    check_int("held_reset_queue_drained", exp_q.size(), 0);

    // Random bouncy sweep: monitor checks exclusion, width and gap only.
    sweep = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) set_btn = ~set_btn;
      if ($urandom_range(0, 7) == 0) reset_btn = ~reset_btn;
    end
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    wait_cycles(80);
    sweep = 1'b0;
    check_int("sweep_busy_idle", int'(busy), 0);
    check_int("final_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
